// File: rtl/result_stream_scheduler_pkg.sv
// Shared message codes, state encoding and sizing helper for the result
// readout path.
package result_stream_scheduler_pkg;

  localparam logic [7:0] START_DECODING_MSG      = 8'h01;
  localparam logic [7:0] MEASUREMENT_DATA_HEADER = 8'h02;
  localparam logic [7:0] RESULT_HEADER_MSG       = 8'hD0;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_HEADER  = 3'd1;
  localparam logic [2:0] ST_ITER    = 3'd2;
  localparam logic [2:0] ST_CYCLE   = 3'd3;
  localparam logic [2:0] ST_FETCH   = 3'd4;
  localparam logic [2:0] ST_CAPTURE = 3'd5;
  localparam logic [2:0] ST_DATA    = 3'd6;
  localparam logic [2:0] ST_DONE    = 3'd7;

  typedef enum logic [2:0] {
    IDLE    = ST_IDLE,
    HEADER  = ST_HEADER,
    ITER    = ST_ITER,
    CYCLE   = ST_CYCLE,
    FETCH   = ST_FETCH,
    CAPTURE = ST_CAPTURE,
    DATA    = ST_DATA,
    DONE    = ST_DONE
  } rss_state_e;

  function automatic int bytes_for_bits(input int bits);
    return (bits + 7) / 8;
  endfunction

endpackage

// File: rtl/result_stream_scheduler_byte_shift_serializer.sv
// Load/shift register that hands out one round's correction vector a byte at
// a time, low byte first, with the last byte zero-padded in its MSBs.
module byte_shift_serializer
  import result_stream_scheduler_pkg::*;
#(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic             shift_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [7:0]       first_byte_o,
  output logic [7:0]       next_byte_o,
  output logic             last_o
);

  localparam int BYTES = bytes_for_bits(WIDTH);
  localparam int PAD_W = BYTES * 8;
  localparam int CNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;

  logic [PAD_W-1:0] padded;
  logic [PAD_W-1:0] shifted;
  logic [PAD_W-1:0] shift_q, shift_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    padded = '0;
    padded[WIDTH-1:0] = data_i;
  end

  // The low byte of shift_q always mirrors the byte the top is presenting,
  // so the byte after a handshake is one position up.
  assign shifted      = shift_q >> 8;
  assign first_byte_o = padded[7:0];
  assign next_byte_o  = shifted[7:0];
  assign last_o       = (cnt_q == CNT_W'(BYTES - 1));

  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    if (load_i) begin
      shift_d = padded;
      cnt_d   = '0;
    end else if (shift_i) begin
      shift_d = shifted;
      cnt_d   = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/result_stream_scheduler.sv
// Streams the decoded result (header, iteration count, cycle count, then each
// round's corrections) out over an 8-bit valid/ready link.
module result_stream_scheduler
  import result_stream_scheduler_pkg::*;
#(
  parameter int GRID_WIDTH_X            = 3,
  parameter int GRID_WIDTH_Z            = 2,
  parameter int GRID_WIDTH_U            = 3,
  parameter int ITERATION_COUNTER_WIDTH = 8,
  localparam int PU_COUNT_PER_ROUND     = GRID_WIDTH_X * GRID_WIDTH_Z,
  localparam int U_BIT_WIDTH            = (GRID_WIDTH_U > 1) ? $clog2(GRID_WIDTH_U) : 1
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               start,
  input  logic [ITERATION_COUNTER_WIDTH-1:0] iteration_count,
  input  logic [31:0]                        cycle_count,
  output logic [U_BIT_WIDTH-1:0]             round_select,
  input  logic [PU_COUNT_PER_ROUND-1:0]      correction_data,
  output logic [7:0]                         output_data,
  output logic                               output_valid,
  input  logic                               output_ready,
  output logic                               busy,
  output logic                               done
);

  rss_state_e             state_q, state_d;
  logic                   valid_q, valid_d;
  logic [7:0]             data_q, data_d;
  logic [U_BIT_WIDTH-1:0] round_q, round_d;
  logic [1:0]             cyc_q, cyc_d;
  logic [7:0]             iter_q, iter_d;
  logic [31:0]            cycle_q, cycle_d;
  logic [7:0]             iter_ext;
  logic                   hs;
  logic                   ser_load, ser_shift, ser_last;
  logic [7:0]             ser_first, ser_next;

  always_comb begin
    iter_ext = '0;
    iter_ext[ITERATION_COUNTER_WIDTH-1:0] = iteration_count;
  end

  assign hs = valid_q && output_ready;

  byte_shift_serializer #(
    .WIDTH(PU_COUNT_PER_ROUND)
  ) u_serializer (
    .clk          (clk),
    .reset        (reset),
    .load_i       (ser_load),
    .shift_i      (ser_shift),
    .data_i       (correction_data),
    .first_byte_o (ser_first),
    .next_byte_o  (ser_next),
    .last_o       (ser_last)
  );

  // Output byte and valid are computed one cycle ahead so both leave flops.
  always_comb begin
    state_d   = state_q;
    valid_d   = valid_q;
    data_d    = data_q;
    round_d   = round_q;
    cyc_d     = cyc_q;
    iter_d    = iter_q;
    cycle_d   = cycle_q;
    ser_load  = 1'b0;
    ser_shift = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          iter_d  = iter_ext;
          cycle_d = cycle_count;
          round_d = '0;
          valid_d = 1'b1;
          data_d  = RESULT_HEADER_MSG;
          state_d = HEADER;
        end
      end
      HEADER: begin
        if (hs) begin
          data_d  = iter_q;
          state_d = ITER;
        end
      end
      ITER: begin
        if (hs) begin
          cyc_d   = 2'd0;
          data_d  = cycle_q[31:24];
          state_d = CYCLE;
        end
      end
      CYCLE: begin
        if (hs) begin
          cyc_d = cyc_q + 2'd1;
          case (cyc_q)
            2'd0:    data_d = cycle_q[23:16];
            2'd1:    data_d = cycle_q[15:8];
            2'd2:    data_d = cycle_q[7:0];
            default: begin
              valid_d = 1'b0;
              data_d  = '0;
              round_d = '0;
              state_d = FETCH;
            end
          endcase
        end
      end
      FETCH: begin
        state_d = CAPTURE;
      end
      CAPTURE: begin
        ser_load = 1'b1;
        valid_d  = 1'b1;
        data_d   = ser_first;
        state_d  = DATA;
      end
      DATA: begin
        if (hs) begin
          if (ser_last) begin
            valid_d = 1'b0;
            data_d  = '0;
            if (round_q == U_BIT_WIDTH'(GRID_WIDTH_U - 1)) begin
              round_d = '0;
              state_d = DONE;
            end else begin
              round_d = round_q + 1'b1;
              state_d = FETCH;
            end
          end else begin
            ser_shift = 1'b1;
            data_d    = ser_next;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
        data_d  = '0;
        round_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      data_q  <= '0;
      round_q <= '0;
      cyc_q   <= '0;
      iter_q  <= '0;
      cycle_q <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      round_q <= round_d;
      cyc_q   <= cyc_d;
      iter_q  <= iter_d;
      cycle_q <= cycle_d;
    end
  end

  assign output_valid = valid_q;
  assign output_data  = data_q;
  assign round_select = round_q;
  assign busy         = (state_q != IDLE);
  assign done         = (state_q == DONE);

endmodule

// File: tb/tb_result_stream_scheduler.sv
// Directed bench for result_stream_scheduler: default geometry plus a second
// instance with 10-bit rounds to exercise multi-byte padding.
module tb_result_stream_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  iteration_count;
  logic [31:0] cycle_count;
  logic [1:0]  round_select;
  logic [5:0]  correction_data;
  logic [7:0]  output_data;
  logic        output_valid;
  logic        output_ready;
  logic        busy;
  logic        done;

  logic        b_start;
  logic [7:0]  b_iteration_count;
  logic [31:0] b_cycle_count;
  logic [1:0]  b_round_select;
  logic [9:0]  b_correction_data;
  logic [7:0]  b_output_data;
  logic        b_output_valid;
  logic        b_output_ready;
  logic        b_busy;
  logic        b_done;

  int compared = 0;
  int failed   = 0;

  logic [5:0]  corrA [3];
  logic [9:0]  corrB [3];
  logic [1:0]  selA = 2'd0;
  logic [1:0]  selB = 2'd0;
  logic [7:0]  bytesA [$];
  logic [7:0]  bytesB [$];
  logic [1:0]  traceA [$];
  int          doneA = 0;
  int          doneB = 0;
  logic        prevStall = 1'b0;
  logic [7:0]  prevData = 8'h00;
  bit          toggleReady = 1'b0;
  logic [15:0] readyPat = 16'b1001_0110_1100_1001;

  always #5 clk = ~clk;

  result_stream_scheduler dut (
    .clk             (clk),
    .reset           (rst_n),
    .start           (start),
    .iteration_count (iteration_count),
    .cycle_count     (cycle_count),
    .round_select    (round_select),
    .correction_data (correction_data),
    .output_data     (output_data),
    .output_valid    (output_valid),
    .output_ready    (output_ready),
    .busy            (busy),
    .done            (done)
  );

  result_stream_scheduler #(
    .GRID_WIDTH_X(5),
    .GRID_WIDTH_Z(2),
    .GRID_WIDTH_U(3)
  ) dut2 (
    .clk             (clk),
    .reset           (rst_n),
    .start           (b_start),
    .iteration_count (b_iteration_count),
    .cycle_count     (b_cycle_count),
    .round_select    (b_round_select),
    .correction_data (b_correction_data),
    .output_data     (b_output_data),
    .output_valid    (b_output_valid),
    .output_ready    (b_output_ready),
    .busy            (b_busy),
    .done            (b_done)
  );

  // PE array model: corrections follow round_select with one cycle of latency.
  always @(negedge clk) begin
    selA = round_select;
    selB = b_round_select;
  end

  always @(posedge clk) begin
    #1;
    correction_data   = corrA[selA];
    b_correction_data = corrB[selB];
  end

  // Link monitor: records accepted bytes and checks data holds under stall.
  always @(negedge clk) begin
    if (rst_n) begin
      if (prevStall) begin
        compared++;
        if (output_valid !== 1'b1 || output_data !== prevData) begin
          failed++;
          $display("[TB] FAIL hold_stable: actual valid=%b data=%h, required valid=1 data=%h",
                   output_valid, output_data, prevData);
        end
      end
      prevStall = output_valid && !output_ready;
      prevData  = output_data;
      if (output_valid && output_ready) bytesA.push_back(output_data);
      if (b_output_valid && b_output_ready) bytesB.push_back(b_output_data);
      if (done) doneA++;
      if (b_done) doneB++;
      if (busy) traceA.push_back(round_select);
    end else begin
      prevStall = 1'b0;
    end
  end

  task automatic clearRecords();
    bytesA.delete();
    bytesB.delete();
    traceA.delete();
    doneA = 0;
    doneB = 0;
  endtask

  task automatic pulseStart();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic waitDone(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #1;
      if (toggleReady) output_ready = readyPat[i % 16];
      if (doneA > 0 || doneB > 0) begin
        ok = 1'b1;
        break;
      end
    end
    compared++;
    if (!ok) begin
      failed++;
      $display("[TB] FAIL %s_timeout: actual no done within 200 cycles, required done pulse", name);
    end
    toggleReady  = 1'b0;
    output_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #23;
    compared += 5;
    if (output_valid !== 1'b0) begin failed++; $display("[TB] FAIL reset_valid: actual %b, required 0", output_valid); end
    if (output_data !== 8'h00) begin failed++; $display("[TB] FAIL reset_data: actual %h, required 00", output_data); end
    if (round_select !== 2'd0) begin failed++; $display("[TB] FAIL reset_round: actual %0d, required 0", round_select); end
    if (busy !== 1'b0) begin failed++; $display("[TB] FAIL reset_busy: actual %b, required 0", busy); end
    if (done !== 1'b0) begin failed++; $display("[TB] FAIL reset_done: actual %b, required 0", done); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic checkFrameA(input string name, input logic [7:0] exp [9]);
    compared++;
    if (bytesA.size() != 9) begin
      failed++;
      $display("[TB] FAIL %s_len: actual %0d bytes, required 9", name, bytesA.size());
    end
    for (int i = 0; i < 9; i++) begin
      logic [7:0] got;
      got = (i < bytesA.size()) ? bytesA[i] : 8'hxx;
      compared++;
      if (got !== exp[i]) begin
        failed++;
        $display("[TB] FAIL %s_byte%0d: actual %h, required %h", name, i, got, exp[i]);
      end
    end
    compared += 2;
    if (doneA != 1) begin failed++; $display("[TB] FAIL %s_done_count: actual %0d, required 1", name, doneA); end
    if (busy !== 1'b0) begin failed++; $display("[TB] FAIL %s_busy_after: actual %b, required 0", name, busy); end
  endtask

  task automatic test_basic();
    logic [7:0] exp [9];
    exp = '{8'hD0, 8'h05, 8'h00, 8'h01, 8'h23, 8'h45, 8'h21, 8'h0C, 8'h3F};
    clearRecords();
    iteration_count = 8'd5;
    cycle_count     = 32'h0001_2345;
    pulseStart();
    waitDone("basic");
    checkFrameA("basic", exp);
  endtask

  task automatic test_backpressure();
    logic [7:0] exp [9];
    exp = '{8'hD0, 8'h05, 8'h00, 8'h01, 8'h23, 8'h45, 8'h21, 8'h0C, 8'h3F};
    clearRecords();
    iteration_count = 8'd5;
    cycle_count     = 32'h0001_2345;
    toggleReady     = 1'b1;
    pulseStart();
    waitDone("backpressure");
    checkFrameA("backpressure", exp);
  endtask

  task automatic test_wide();
    logic [7:0] exp [12];
    exp = '{8'hD0, 8'h07, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h55, 8'h01, 8'hA5, 8'h02, 8'hFF, 8'h03};
    clearRecords();
    b_iteration_count = 8'h07;
    b_cycle_count     = 32'hDEAD_BEEF;
    @(posedge clk);
    #1 b_start = 1'b1;
    @(posedge clk);
    #1 b_start = 1'b0;
    waitDone("wide");
    compared++;
    if (bytesB.size() != 12) begin
      failed++;
      $display("[TB] FAIL wide_len: actual %0d bytes, required 12", bytesB.size());
    end
    for (int i = 0; i < 12; i++) begin
      logic [7:0] got;
      got = (i < bytesB.size()) ? bytesB[i] : 8'hxx;
      compared++;
      if (got !== exp[i]) begin
        failed++;
        $display("[TB] FAIL wide_byte%0d: actual %h, required %h", i, got, exp[i]);
      end
    end
    compared++;
    if (doneB != 1) begin failed++; $display("[TB] FAIL wide_done_count: actual %0d, required 1", doneB); end
  endtask

  task automatic test_back_to_back_start();
    logic [7:0] exp [9];
    exp = '{8'hD0, 8'h05, 8'h00, 8'h01, 8'h23, 8'h45, 8'h21, 8'h0C, 8'h3F};
    clearRecords();
    iteration_count = 8'd5;
    cycle_count     = 32'h0001_2345;
    pulseStart();
    repeat (2) @(posedge clk);
    #1;
    start           = 1'b1;
    iteration_count = 8'h63;
    cycle_count     = 32'hFFFF_FFFF;
    compared++;
    if (busy !== 1'b1) begin failed++; $display("[TB] FAIL restart_busy: actual %b, required 1", busy); end
    @(posedge clk);
    #1 start = 1'b0;
    waitDone("restart");
    repeat (20) @(posedge clk);
    #1;
    checkFrameA("restart", exp);
    compared++;
    if (output_valid !== 1'b0) begin failed++; $display("[TB] FAIL restart_idle_valid: actual %b, required 0", output_valid); end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] exp [9];
    bit found;
    exp = '{8'hD0, 8'h11, 8'hCA, 8'hFE, 8'hF0, 8'h0D, 8'h21, 8'h0C, 8'h3F};
    clearRecords();
    iteration_count = 8'd5;
    cycle_count     = 32'h0001_2345;
    pulseStart();
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (round_select == 2'd1 && output_valid == 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    compared++;
    if (!found) begin failed++; $display("[TB] FAIL midreset_reach: actual round1 DATA not seen, required seen"); end
    #2 rst_n = 1'b0;
    #1;
    compared += 4;
    if (output_valid !== 1'b0) begin failed++; $display("[TB] FAIL midreset_valid: actual %b, required 0", output_valid); end
    if (busy !== 1'b0) begin failed++; $display("[TB] FAIL midreset_busy: actual %b, required 0", busy); end
    if (round_select !== 2'd0) begin failed++; $display("[TB] FAIL midreset_round: actual %0d, required 0", round_select); end
    if (output_data !== 8'h00) begin failed++; $display("[TB] FAIL midreset_data: actual %h, required 00", output_data); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    clearRecords();
    iteration_count = 8'h11;
    cycle_count     = 32'hCAFE_F00D;
    pulseStart();
    waitDone("midreset");
    checkFrameA("midreset", exp);
  endtask

  task automatic test_round_trace();
    logic [1:0] exp [16];
    exp = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0,
            2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd0};
    clearRecords();
    iteration_count = 8'd5;
    cycle_count     = 32'h0001_2345;
    pulseStart();
    waitDone("trace");
    compared++;
    if (traceA.size() != 16) begin
      failed++;
      $display("[TB] FAIL trace_len: actual %0d busy cycles, required 16", traceA.size());
    end
    for (int i = 0; i < 16; i++) begin
      logic [1:0] got;
      got = (i < traceA.size()) ? traceA[i] : 2'bxx;
      compared++;
      if (got !== exp[i]) begin
        failed++;
        $display("[TB] FAIL trace_cycle%0d: actual round %0d, required %0d", i, got, exp[i]);
      end
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: actual simulation still running, required finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    corrA[0] = 6'h21;
    corrA[1] = 6'h0C;
    corrA[2] = 6'h3F;
    corrB[0] = 10'h155;
    corrB[1] = 10'h2A5;
    corrB[2] = 10'h3FF;
    start             = 1'b0;
    iteration_count   = 8'h00;
    cycle_count       = 32'h0;
    output_ready      = 1'b1;
    correction_data   = 6'h00;
    b_start           = 1'b0;
    b_iteration_count = 8'h00;
    b_cycle_count     = 32'h0;
    b_output_ready    = 1'b1;
    b_correction_data = 10'h000;

    test_reset();
    test_basic();
    test_backpressure();
    test_wide();
    test_back_to_back_start();
    test_reset_mid_frame();
    test_round_trace();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule

// File: doc/result_stream_scheduler.md
Name: result_stream_scheduler

Overview:
- Sequences readout of the decoded result after the stage controller signals result valid.
- Snapshots the iteration and cycle counters, then walks the per-round correction vectors of the PE array one round at a time.
- Serialises everything into an 8-bit valid/ready output byte stream.
- Sits between the stage controller / PE array and the external output link, and owns the round-select mux of the correction readout path.

Parameters:
GRID_WIDTH_X, 3, PE grid width in X
GRID_WIDTH_Z, 2, PE grid width in Z
GRID_WIDTH_U, 3, number of measurement rounds
ITERATION_COUNTER_WIDTH, 8, width of the iteration count input (≤8)
Derived: PU_COUNT_PER_ROUND = X*Z; BYTES_PER_ROUND = ceil(PU_COUNT_PER_ROUND/8); U_BIT_WIDTH = max(1, clog2(GRID_WIDTH_U))

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
start  in  1  one-cycle pulse from the stage controller when the result is valid
iteration_count  in  ITERATION_COUNTER_WIDTH  grow iterations used
cycle_count  in  32  decode cycle count
round_select  out  U_BIT_WIDTH  selects which round's corrections the PE array presents
correction_data  in  PU_COUNT_PER_ROUND  corrections of the selected round; valid 1 cycle after round_select changes
output_data  out  8  stream byte
output_valid  out  1  byte valid
output_ready  in  1  sink accepts byte
busy  out  1  high from the cycle after an accepted start until the DONE cycle inclusive
done  out  1  one-cycle pulse after the last byte handshake

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; output_valid=0, output_data=0, round_select=0, busy=0, done=0.
  - All snapshot registers are cleared.
  - Reset mid-frame drops the frame immediately; no partial resume.
- Frame format, bytes in order:
  - RESULT_HEADER_MSG.
  - iteration_count, zero-extended to 8 bits.
  - cycle_count[31:24], [23:16], [15:8], [7:0].
  - For u = 0..GRID_WIDTH_U-1: BYTES_PER_ROUND bytes of correction_data, bits [7:0] first. The final byte is zero-padded in the MSBs.
  - Total = 6 + GRID_WIDTH_U*BYTES_PER_ROUND bytes.
- States: IDLE, HEADER, ITER, CYCLE, FETCH, CAPTURE, DATA, DONE.
- IDLE:
  - start=1 → latch iteration_count and cycle_count, go to HEADER.
  - output_valid rises on the next cycle with the header byte.
- HEADER / ITER: present the byte; advance on output_valid && output_ready.
- CYCLE: 2-bit byte counter 0..3, MSB first; after the byte-3 handshake go to FETCH with round_select=0.
- FETCH: output_valid=0; wait one cycle for readout latency → CAPTURE.
- CAPTURE: load correction_data into the shift register, reset the byte counter → DATA.
- DATA:
  - Present shift[7:0]. On handshake, shift right by 8 with zero fill and increment the byte counter.
  - After BYTES_PER_ROUND handshakes: if round_select == GRID_WIDTH_U-1 → DONE; else round_select+1 → FETCH.
- DONE: done=1 for one cycle, round_select=0 → IDLE.
- Handshake rules:
  - output_data and output_valid are registered.
  - While output_valid=1 and output_ready=0, output_data is held stable and the state does not advance.
  - Back-to-back bytes are required within a phase: no bubble when output_ready is held high. There is exactly one bubble cycle pair (FETCH, CAPTURE) per round.
  - output_ready while output_valid=0 is ignored.
- start while busy is ignored and produces no error or second frame. start coincident with DONE is also ignored.
- cycle_count and iteration_count changes after the snapshot do not affect the frame.
- round_select is held constant for the whole FETCH/CAPTURE/DATA span of a round.

Decomposition:
- Shared parameters package holds:
  - RESULT_HEADER_MSG (8'hD0), alongside START_DECODING_MSG and MEASUREMENT_DATA_HEADER.
  - The state encoding localparams, width 3.
- One natural sub-module: byte_shift_serializer. It holds the PU_COUNT_PER_ROUND-bit load/shift register with byte counter and last-byte flag, parameterised by width. The FSM stays in the top.

Test Plan:
1. Defaults (X=3, Z=2, U=3), output_ready=1, iteration_count=5, cycle_count=32'h00012345, rounds' corrections 6'h21/6'h0C/6'h3F → 9 bytes D0,05,00,01,23,45,21,0C,3F. Exactly one done pulse; busy low after.
2. Same stimulus with output_ready toggling 1-0-0-1 pseudo-randomly → identical byte sequence; output_data never changes while valid && !ready.
3. X=5, Z=2 (10 bits/round), round 1 = 10'h2A5 → round-1 bytes A5 then 02 (zero-padded); total 12 bytes.
4. start pulsed again during CYCLE phase → ignored; a single 9-byte frame; cycle_count changed after start does not alter bytes 2-5.
5. reset asserted low during the DATA phase of round 1 → output_valid=0, busy=0, round_select=0 without waiting for clk. A new start after release yields a full frame from the header.
6. round_select trace with ready=1: 0 throughout the header bytes, then 0 → 1 → 2, each held for the FETCH + CAPTURE + BYTES_PER_ROUND cycles of its round. The correction value presented before FETCH completes is not sampled.
